// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit controller issuing one aligned word access per request
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned H/HU/W faults instead of forcing the offset down)
module lsu_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  memop,
   input  logic        memwr,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [2:0]  memop_q;
   logic        memwr_q;
   logic        fault_q;
   logic        start_fault;
   logic        access_act;
   logic [1:0]  off;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_val;
   logic [31:0] st_data;
   logic [3:0]  st_mask;

   // Fault decision is made on the raw request so ACCESS never raises mem_req for it.
   always_comb begin
      start_fault = 1'b0;
      case (memop)
         3'b011, 3'b110, 3'b111: start_fault = 1'b1;
         3'b100, 3'b101:         start_fault = memwr;
         default:                start_fault = 1'b0;
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      if ((memop[1:0] == 2'b01) && addr[0])
         start_fault = 1'b1;
      if ((memop == 3'b010) && (addr[1:0] != 2'b00))
         start_fault = 1'b1;
`endif
   end

   // Lane offset aligned down to the access size.
   always_comb begin
      case (memop_q[1:0])
         2'b00:   off = addr_q[1:0];
         2'b01:   off = {addr_q[1], 1'b0};
         default: off = 2'b00;
      endcase
   end

   always_comb begin
      ld_byte = mem_rdata[{off, 3'b000} +: 8];
      ld_half = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (memop_q)
         3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  load_val = {24'd0, ld_byte};
         3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
         3'b101:  load_val = {16'd0, ld_half};
         default: load_val = mem_rdata;
      endcase
   end

   always_comb begin
      case (memop_q[1:0])
         2'b00: begin
            st_data = {4{wdata_q[7:0]}};
            st_mask = 4'b0001 << off;
         end
         2'b01: begin
            st_data = {2{wdata_q[15:0]}};
            st_mask = 4'b0011 << off;
         end
         default: begin
            st_data = wdata_q;
            st_mask = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      busy       = 1'b1;
      done       = 1'b0;
      err        = 1'b0;
      access_act = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start)
               state_nx = ACCESS;
         end
         ACCESS: begin
            access_act = ~fault_q;
            if (fault_q || mem_ready)
               state_nx = RESP;
         end
         RESP: begin
            done     = 1'b1;
            err      = fault_q;
            state_nx = IDLE;
         end
         default: begin
            busy     = 1'b0;
            state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         memop_q <= 3'd0;
         memwr_q <= 1'b0;
         fault_q <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         if ((state == IDLE) && start) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            memop_q <= memop;
            memwr_q <= memwr;
            fault_q <= start_fault;
         end
         if (access_act && mem_ready && !memwr_q)
            rdata_q <= load_val;
      end
   end

   assign mem_req   = access_act;
   assign mem_we    = access_act & memwr_q;
   assign mem_addr  = {addr_q[31:2], 2'b00};
   assign mem_wdata = st_data;
   assign mem_wmask = (access_act && memwr_q) ? st_mask : 4'b0000;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl with a byte-lane reference model
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [2:0]  memop;
   logic        memwr;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   lsu_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .addr      (addr),
      .wdata     (wdata),
      .memop     (memop),
      .memwr     (memwr),
      .busy      (busy),
      .done      (done),
      .rdata     (rdata),
      .err       (err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wmask (mem_wmask),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          reqs;
      int          t0;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          req_cnt = 0;
   logic        e_req = 1'b0;
   logic        e_we = 1'b0;
   logic [31:0] e_addr = 32'd0;
   logic [31:0] e_wdata = 32'd0;
   logic [3:0]  e_wmask = 4'd0;
   logic [31:0] last_rd = 32'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: memory side checked every request cycle, responses popped from the scoreboard on done.
   always @(negedge clk) begin
      if (!rst_n) begin
         req_cnt = 0;
      end else begin
         if (mem_req) begin
            req_cnt++;
            if (!e_req) begin
               total++;
               bad++;
               $display("FAIL unexpected_mem_req actual=1 required=0 addr=%h", mem_addr);
            end else begin
               chk("mem_addr", mem_addr, e_addr);
               chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
               chk("mem_wmask", {28'd0, mem_wmask}, {28'd0, e_wmask});
               if (e_we)
                  chk("mem_wdata", mem_wdata, e_wdata);
            end
         end
         if (done) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_done actual=1 required=0");
            end else begin
               mon_e = sbq.pop_front();
               chk("rdata", rdata, mon_e.rdata);
               chk("err", {31'd0, err}, {31'd0, mon_e.err});
               chk("latency", cyc - mon_e.t0, mon_e.lat);
               chk("req_cycles", req_cnt, mon_e.reqs);
            end
            req_cnt = 0;
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] w, input logic [2:0] op,
                        input logic we, input int d, input logic [31:0] mr);
      exp_t        e;
      int          sz;
      int          oi;
      logic        f;
      logic [3:0]  m;
      logic [31:0] wd;
      logic [31:0] v;
      logic [31:0] lim;
      sz = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
      f  = (op == 3'b011) || (op == 3'b110) || (op == 3'b111) || (we && op[2]);
      oi = int'(a[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
      if ((oi % sz) != 0)
         f = 1'b1;
`endif
      oi = oi - (oi % sz);
      m  = 4'(((1 << sz) - 1) << oi);
      for (int i = 0; i < 4; i++)
         wd[8*i +: 8] = w[8*(i % sz) +: 8];
      v = mr >> (8 * oi);
      if (sz < 4) begin
         lim = (32'd1 << (8 * sz)) - 32'd1;
         v = v & lim;
         if (!op[2] && v[8*sz-1])
            v = v | ~lim;
      end
      if (!f && !we)
         last_rd = v;
      e.rdata = last_rd;
      e.err   = f;
      e.lat   = f ? 2 : d + 2;
      e.reqs  = f ? 0 : d + 1;

      @(negedge clk);
      e_addr  = {a[31:2], 2'b00};
      e_we    = we;
      e_wmask = we ? m : 4'd0;
      e_wdata = wd;
      e_req   = !f;
      e.t0    = cyc;
      sbq.push_back(e);
      addr = a; wdata = w; memop = op; memwr = we; start = 1'b1; mem_ready = 1'b0;
      @(negedge clk);
      start = 1'b0; addr = $urandom; wdata = $urandom; memop = 3'($urandom); memwr = 1'($urandom);
      if (!f) begin
         for (int i = 0; i < d; i++) begin
            mem_rdata = $urandom;
            start = 1'($urandom);
            @(negedge clk);
         end
         start = 1'b0; mem_rdata = mr; mem_ready = 1'b1;
      end
      @(negedge clk);
      mem_ready = 1'($urandom); mem_rdata = $urandom; e_req = 1'b0;
      @(negedge clk);
      mem_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; addr = 32'd0; wdata = 32'd0; memop = 3'd0; memwr = 1'b0;
      mem_ready = 1'b0; mem_rdata = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      rst_n = 1'b1;

      issue(32'h103, 32'h0, 3'b000, 1'b0, 0, 32'h8000_0000);
      chk("load_b_sext", rdata, 32'hFFFF_FF80);
      issue(32'h22, 32'h1234_ABCD, 3'b001, 1'b1, 3, 32'h0);
      chk("store_h_keeps_rdata", rdata, 32'hFFFF_FF80);
      issue(32'h42, 32'h0, 3'b101, 1'b0, 2, 32'h9ABC_0000);
      chk("load_hu_zext", rdata, 32'h0000_9ABC);
      issue(32'h101, 32'h0, 3'b010, 1'b0, 0, 32'hCAFE_F00D);
      issue(32'h40, 32'h0, 3'b111, 1'b0, 0, 32'h0);
      issue(32'h41, 32'h55, 3'b100, 1'b1, 0, 32'h0);

      // Reset in the middle of an access.
      @(negedge clk);
      addr = 32'h200; memop = 3'b010; memwr = 1'b0; start = 1'b1;
      e_req = 1'b1; e_addr = 32'h200; e_we = 1'b0; e_wmask = 4'd0;
      @(negedge clk);
      start = 1'b0;
      chk("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      e_req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      last_rd = 32'd0;
      chk("post_rst_rdata", rdata, 32'd0);

      for (int n = 0; n < 150; n++) begin
         logic [2:0] op;
         int r;
         r = $urandom_range(0, 9);
         case (r)
            0, 1:    op = 3'b000;
            2, 3:    op = 3'b001;
            4, 5:    op = 3'b010;
            6:       op = 3'b100;
            7:       op = 3'b101;
            default: op = 3'($urandom);
         endcase
         issue($urandom, $urandom, op, 1'($urandom), $urandom_range(0, 4), $urandom);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sbq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
